// File: rtl/machine_state_loader.sv
// Byte-stream command decoder that preloads the register file, data memory and PC,
// then releases the single-cycle machine from reset on GO.
module machine_state_loader (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic        in_ready,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        pc_we,
    output logic [29:0] pc_wdata,
    output logic        cpu_reset,
    output logic        err,
    output logic [2:0]  dbg_state
);

    // Handshake: a byte transfers on a rising edge where in_valid and in_ready are both 1;
    // in_ready is registered and high only in IDLE and ARGS.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARGS   = 3'd1,
        S_COMMIT = 3'd2,
        S_RUN    = 3'd3,
        S_ERR    = 3'd4
    } state_t;

    localparam logic [1:0] C_REG = 2'd0;
    localparam logic [1:0] C_MEM = 2'd1;
    localparam logic [1:0] C_PC  = 2'd2;

    state_t      r_state, w_state_nxt;
    logic [2:0]  r_cnt, w_cnt_nxt;
    logic [1:0]  r_cmd, w_cmd_nxt;
    logic [63:0] r_args, w_args_nxt;
    logic [63:0] w_shift;
    logic        w_xfer;

    logic        r_in_ready, w_in_ready_nxt;
    logic        r_rf_we, w_rf_we_nxt;
    logic [4:0]  r_rf_waddr, w_rf_waddr_nxt;
    logic [31:0] r_rf_wdata, w_rf_wdata_nxt;
    logic        r_mem_we, w_mem_we_nxt;
    logic [29:0] r_mem_addr, w_mem_addr_nxt;
    logic [31:0] r_mem_wdata, w_mem_wdata_nxt;
    logic        r_pc_we, w_pc_we_nxt;
    logic [29:0] r_pc_wdata, w_pc_wdata_nxt;
    logic        r_cpu_reset, w_cpu_reset_nxt;
    logic        r_err, w_err_nxt;

    assign w_xfer  = in_valid & r_in_ready;
    // Bytes enter at the top, so an n-byte command ends up little-endian in args[63:64-8n].
    assign w_shift = {in_byte, r_args[63:8]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= 3'd0;
            r_cmd       <= C_REG;
            r_args      <= 64'd0;
            r_in_ready  <= 1'b0;
            r_rf_we     <= 1'b0;
            r_rf_waddr  <= 5'd0;
            r_rf_wdata  <= 32'd0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 30'd0;
            r_mem_wdata <= 32'd0;
            r_pc_we     <= 1'b0;
            r_pc_wdata  <= 30'd0;
            r_cpu_reset <= 1'b1;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_cmd       <= w_cmd_nxt;
            r_args      <= w_args_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_rf_we     <= w_rf_we_nxt;
            r_rf_waddr  <= w_rf_waddr_nxt;
            r_rf_wdata  <= w_rf_wdata_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_pc_we     <= w_pc_we_nxt;
            r_pc_wdata  <= w_pc_wdata_nxt;
            r_cpu_reset <= w_cpu_reset_nxt;
            r_err       <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_cmd_nxt       = r_cmd;
        w_args_nxt      = r_args;
        w_rf_we_nxt     = 1'b0;
        w_rf_waddr_nxt  = r_rf_waddr;
        w_rf_wdata_nxt  = r_rf_wdata;
        w_mem_we_nxt    = 1'b0;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_pc_we_nxt     = 1'b0;
        w_pc_wdata_nxt  = r_pc_wdata;

        case (r_state)
            S_IDLE: begin
                if (w_xfer) begin
                    case (in_byte)
                        8'h01: begin w_cmd_nxt = C_REG; w_cnt_nxt = 3'd4; w_state_nxt = S_ARGS; end
                        8'h02: begin w_cmd_nxt = C_MEM; w_cnt_nxt = 3'd7; w_state_nxt = S_ARGS; end
                        8'h03: begin w_cmd_nxt = C_PC;  w_cnt_nxt = 3'd3; w_state_nxt = S_ARGS; end
                        8'h04:   w_state_nxt = S_RUN;
                        default: w_state_nxt = S_ERR;
                    endcase
                end
            end
            S_ARGS: begin
                if (w_xfer) begin
                    w_args_nxt = w_shift;
                    if (r_cnt != 3'd0) begin
                        w_cnt_nxt = r_cnt - 3'd1;
                    end else begin
                        // Validate on the final byte so a bad command never reaches COMMIT.
                        w_state_nxt = S_COMMIT;
                        case (r_cmd)
                            C_REG: begin
                                if (|w_shift[31:29]) begin
                                    w_state_nxt = S_ERR;
                                end else begin
                                    w_rf_we_nxt    = 1'b1;
                                    w_rf_waddr_nxt = w_shift[28:24];
                                    w_rf_wdata_nxt = w_shift[63:32];
                                end
                            end
                            C_MEM: begin
                                if (|w_shift[1:0]) begin
                                    w_state_nxt = S_ERR;
                                end else begin
                                    w_mem_we_nxt    = 1'b1;
                                    w_mem_addr_nxt  = w_shift[31:2];
                                    w_mem_wdata_nxt = w_shift[63:32];
                                end
                            end
                            C_PC: begin
                                if (|w_shift[33:32]) begin
                                    w_state_nxt = S_ERR;
                                end else begin
                                    w_pc_we_nxt    = 1'b1;
                                    w_pc_wdata_nxt = w_shift[63:34];
                                end
                            end
                            default: w_state_nxt = S_ERR;
                        endcase
                    end
                end
            end
            S_COMMIT: w_state_nxt = S_IDLE;
            S_RUN:    w_state_nxt = S_RUN;
            S_ERR:    w_state_nxt = S_ERR;
            default:  w_state_nxt = S_ERR;
        endcase

        w_in_ready_nxt  = (w_state_nxt == S_IDLE) || (w_state_nxt == S_ARGS);
        w_cpu_reset_nxt = (w_state_nxt != S_RUN);
        w_err_nxt       = (w_state_nxt == S_ERR);
    end

    assign in_ready  = r_in_ready;
    assign rf_we     = r_rf_we;
    assign rf_waddr  = r_rf_waddr;
    assign rf_wdata  = r_rf_wdata;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign pc_we     = r_pc_we;
    assign pc_wdata  = r_pc_wdata;
    assign cpu_reset = r_cpu_reset;
    assign err       = r_err;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_machine_state_loader.sv
// Directed bench for machine_state_loader: command streams with hand-computed strobes.
module tb_machine_state_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_byte = 8'h00;
    logic        in_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        pc_we;
    logic [29:0] pc_wdata;
    logic        cpu_reset;
    logic        err;
    logic [2:0]  dbg_state;

    int n_cmp = 0;
    int n_err = 0;
    int rf_seen = 0;
    int mem_seen = 0;
    int pc_seen = 0;
    int rf0, mem0, pc0;

    machine_state_loader dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_byte(in_byte),
        .in_ready(in_ready), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .pc_we(pc_we), .pc_wdata(pc_wdata), .cpu_reset(cpu_reset), .err(err),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rf_we)  rf_seen++;
        if (mem_we) mem_seen++;
        if (pc_we)  pc_seen++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one byte after 'gap' idle cycles; returns just after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        t = 0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        in_byte  = b;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("accept_timeout", 64'(t < 20), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b0;
        #2;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_cpu_reset", 64'(cpu_reset), 64'd1);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_strobes", 64'({rf_we, mem_we, pc_we}), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_in_ready", 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [7:0] reg_a [6];
        logic [7:0] reg_b [6];
        reg_a = '{8'h01, 8'h0F, 8'h10, 8'h00, 8'h40, 8'h00};
        reg_b = '{8'h01, 8'h1F, 8'h78, 8'h56, 8'h34, 8'h12};

        // Power-on reset: outputs cleared.
        repeat (2) @(negedge clk);
        chk("por_in_ready", 64'(in_ready), 64'd0);
        chk("por_cpu_reset", 64'(cpu_reset), 64'd1);
        chk("por_err", 64'(err), 64'd0);
        chk("por_addrs", 64'({rf_waddr, mem_addr, pc_wdata}), 64'd0);
        chk("por_data", {rf_wdata, mem_wdata}, 64'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("por_rel_ready", 64'(in_ready), 64'd1);

        // REG 15 <= 0x00400010.
        rf0 = rf_seen; mem0 = mem_seen; pc0 = pc_seen;
        for (int i = 0; i < 6; i++) send_byte(reg_a[i], 0);
        chk("reg_we", 64'(rf_we), 64'd1);
        chk("reg_waddr", 64'(rf_waddr), 64'd15);
        chk("reg_wdata", 64'(rf_wdata), 64'h0040_0010);
        chk("reg_ready_low", 64'(in_ready), 64'd0);
        chk("reg_other_we", 64'({mem_we, pc_we}), 64'd0);
        @(posedge clk); #1;
        chk("reg_we_drop", 64'(rf_we), 64'd0);
        chk("reg_ready_back", 64'(in_ready), 64'd1);
        chk("reg_counts", 64'({rf_seen - rf0, mem_seen - mem0, pc_seen - pc0}), {32'd0, 32'd1} << 64);

        // MEM word 0x1000 <= 0xDEADBEEF.
        send_byte(8'h02, 0);
        send_byte(8'h00, 0); send_byte(8'h40, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        send_byte(8'hEF, 0); send_byte(8'hBE, 0); send_byte(8'hAD, 0); send_byte(8'hDE, 0);
        chk("mem_we", 64'(mem_we), 64'd1);
        chk("mem_addr", 64'(mem_addr), 64'h1000);
        chk("mem_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
        chk("mem_ready_low", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        chk("mem_we_drop", 64'(mem_we), 64'd0);
        chk("mem_ready_back", 64'(in_ready), 64'd1);
        chk("mem_hold_addr", 64'(mem_addr), 64'h1000);
        chk("rf_hold_waddr", 64'(rf_waddr), 64'd15);
        chk("mem_count", 64'(mem_seen - mem0), 64'd1);

        // PC byte address 0x00400000 -> word 0x100000, then GO.
        send_byte(8'h03, 0);
        send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h40, 0); send_byte(8'h00, 0);
        chk("pc_we", 64'(pc_we), 64'd1);
        chk("pc_wdata", 64'(pc_wdata), 64'h10_0000);
        chk("pc_cpu_reset", 64'(cpu_reset), 64'd1);
        send_byte(8'h04, 0);
        chk("go_cpu_reset", 64'(cpu_reset), 64'd0);
        chk("go_ready", 64'(in_ready), 64'd0);
        rf0 = rf_seen; mem0 = mem_seen; pc0 = pc_seen;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_byte  = (i == 0) ? 8'h01 : 8'h00;
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("run_no_strobes", 64'((rf_seen - rf0) + (mem_seen - mem0) + (pc_seen - pc0)), 64'd0);
        chk("run_cpu_reset", 64'(cpu_reset), 64'd0);
        chk("run_err", 64'(err), 64'd0);

        // Invalid opcode.
        do_reset();
        send_byte(8'h07, 0);
        chk("badop_err", 64'(err), 64'd1);
        chk("badop_ready", 64'(in_ready), 64'd0);
        chk("badop_cpu_reset", 64'(cpu_reset), 64'd1);
        repeat (3) @(negedge clk);
        chk("badop_sticky", 64'(err), 64'd1);

        // Misaligned MEM address: error, no strobe ever.
        do_reset();
        mem0 = mem_seen;
        send_byte(8'h02, 0);
        send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        send_byte(8'hEF, 0); send_byte(8'hBE, 0); send_byte(8'hAD, 0); send_byte(8'hDE, 0);
        chk("misalign_err", 64'(err), 64'd1);
        chk("misalign_we", 64'(mem_we), 64'd0);
        repeat (3) @(negedge clk);
        chk("misalign_count", 64'(mem_seen - mem0), 64'd0);

        // REG index 32 is out of range.
        do_reset();
        rf0 = rf_seen;
        send_byte(8'h01, 0); send_byte(8'h20, 0);
        send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
        chk("regidx_err", 64'(err), 64'd1);
        repeat (2) @(negedge clk);
        chk("regidx_count", 64'(rf_seen - rf0), 64'd0);

        // Gapped REG 31 <= 0x12345678.
        do_reset();
        rf0 = rf_seen;
        for (int i = 0; i < 6; i++) send_byte(reg_b[i], $urandom_range(0, 5));
        chk("gap_we", 64'(rf_we), 64'd1);
        chk("gap_waddr", 64'(rf_waddr), 64'd31);
        chk("gap_wdata", 64'(rf_wdata), 64'h1234_5678);
        @(posedge clk); #1;
        chk("gap_count", 64'(rf_seen - rf0), 64'd1);

        // Reset after 3 of 9 MEM bytes, then a clean REG 3 <= 0xDDCCBBAA.
        mem0 = mem_seen;
        send_byte(8'h02, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        do_reset();
        chk("midrst_mem_count", 64'(mem_seen - mem0), 64'd0);
        chk("midrst_cpu_reset", 64'(cpu_reset), 64'd1);
        send_byte(8'h01, 0); send_byte(8'h03, 0);
        send_byte(8'hAA, 0); send_byte(8'hBB, 0); send_byte(8'hCC, 0); send_byte(8'hDD, 0);
        chk("post_we", 64'(rf_we), 64'd1);
        chk("post_waddr", 64'(rf_waddr), 64'd3);
        chk("post_wdata", 64'(rf_wdata), 64'hDDCC_BBAA);
        chk("post_mem_we", 64'(mem_we), 64'd0);
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/machine_state_loader.md
# machine_state_loader

Byte-stream driven loader that initialises the single-cycle machine before it runs: it decodes a simple command stream and issues register-file, data-memory and PC write strobes, then releases the machine from reset. It is the writer counterpart to the end-of-run state dump the benches perform. It sits between a host byte source (UART/JTAG bridge or bench driver) and the machine's register file, data memory and PC register.

## Interface
- No parameters; all widths fixed to the machine's 32-bit datapath (word-addressed PC and data memory, 32 registers).
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low
- in_valid  in  1  host byte valid
- in_byte  in  8  host byte
- in_ready  out  1  loader accepts byte this cycle (transfer = in_valid & in_ready)
- rf_we  out  1  one-cycle register-file write strobe
- rf_waddr  out  5  register index
- rf_wdata  out  32  register data
- mem_we  out  1  one-cycle data-memory write strobe
- mem_addr  out  30  word address (byte address >> 2)
- mem_wdata  out  32  memory data
- pc_we  out  1  one-cycle PC write strobe
- pc_wdata  out  30  PC word (byte address >> 2)
- cpu_reset  out  1  active-high reset to machine; held 1 until GO
- err  out  1  sticky protocol error

## Operation
- Command = opcode byte + argument bytes, multi-byte fields little-endian:
  - 0x01 REG: 1 index byte, 4 data bytes (5 args).
  - 0x02 MEM: 4 byte-address bytes, 4 data bytes (8 args).
  - 0x03 PC: 4 byte-address bytes (4 args).
  - 0x04 GO: no args.
- States: IDLE (await opcode), ARGS (collect bytes, 3-bit counter), COMMIT (issue strobe), RUN (machine released), ERR.
- IDLE: accepted 0x01-0x03 -> ARGS with count preset; 0x04 -> RUN; any other opcode -> ERR.
- ARGS: each accepted byte shifts into a 64-bit argument register; after last byte -> COMMIT. Gaps (in_valid=0) hold state indefinitely.
- COMMIT validation: REG index > 31 -> ERR; MEM or PC address with bits[1:0] != 0 -> ERR; otherwise exactly one matching strobe, then IDLE.
- RUN: cpu_reset=0, in_ready=0, no further strobes until reset.
- ERR: err=1, in_ready=0, cpu_reset stays 1, no strobes until reset.
- Writes to register 0 are issued as normal; the register file decides.
- Any number of commands, in any order, before GO; later writes to the same target overwrite.

## Timing
- Reset (asynchronous assert): state IDLE, in_ready=0 while reset low, all strobes 0, addr/data outputs 0, cpu_reset=1, err=0, counter 0. First cycle after release: in_ready=1.
- All outputs registered. in_ready=1 in IDLE and ARGS only; it is 0 in COMMIT, RUN and ERR.
- Strobe latency: last argument byte accepted on edge N -> strobe high for cycle N..N+1 with address/data stable, low after edge N+1; in_ready returns to 1 at edge N+1. Minimum command period = arg count + 2 cycles.
- GO accepted on edge N -> cpu_reset=0 and in_ready=0 from edge N.
- Invalid opcode accepted on edge N -> err=1 from edge N. Validation error -> err=1 at the edge that would start COMMIT, and no strobe is ever raised.
- Address/data outputs hold last committed values between strobes.
- Reset mid-command discards partial arguments; no strobe is issued.

## Test plan
- REG: 01 0F 10 00 40 00 -> one cycle rf_we=1, rf_waddr=15, rf_wdata=0x00400010; mem_we and pc_we stay 0.
- MEM: 02 00 40 00 00 EF BE AD DE -> one cycle mem_we=1, mem_addr=0x1000, mem_wdata=0xDEADBEEF; in_ready low exactly that cycle.
- PC then GO: 03 00 00 40 00, 04 -> pc_we=1 with pc_wdata=0x100000; after 04, cpu_reset 1->0, in_ready=0; extra bytes ignored, no strobes.
- Errors: opcode 0x07 -> err=1, in_ready=0, cpu_reset=1; after reset, 02 01 00 00 00 + 4 data bytes -> err=1, mem_we never asserted.
- Backpressure/reset: REG command sent with random 0-5 cycle gaps -> identical strobe and values as gap-free run; reset asserted after 3 of 9 MEM bytes -> no strobe, cpu_reset=1, following complete REG command decoded correctly.
